// File: rtl/lcd_master_0_p2b_converter_if.sv
// Avalon-ST beat in / byte stream out bundle for the packets-to-bytes encoder.
// slave is the encoder side, master is the upstream/downstream environment side.
interface lcd_master_0_p2b_converter_if #(
    parameter int CHANNEL_WIDTH = 8
);
    logic                     in_ready;
    logic                     in_valid;
    logic [7:0]               in_data;
    logic [CHANNEL_WIDTH-1:0] in_channel;
    logic                     in_startofpacket;
    logic                     in_endofpacket;
    logic                     out_ready;
    logic                     out_valid;
    logic [7:0]               out_data;

    modport slave (
        output in_ready,
        input  in_valid,
        input  in_data,
        input  in_channel,
        input  in_startofpacket,
        input  in_endofpacket,
        input  out_ready,
        output out_valid,
        output out_data
    );

    modport master (
        input  in_ready,
        output in_valid,
        output in_data,
        output in_channel,
        output in_startofpacket,
        output in_endofpacket,
        output out_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/lcd_master_0_p2b_converter.sv
// Packets-to-bytes encoder: one Avalon-ST beat -> framed, escaped byte stream.
// Latency one cycle to first byte; registered output, stalls hold out_data.
module lcd_master_0_p2b_converter #(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    lcd_master_0_p2b_converter_if.slave   bus
);

    localparam logic [7:0] SOP_CHAR = 8'h7A;
    localparam logic [7:0] EOP_CHAR = 8'h7B;
    localparam logic [7:0] CH_CHAR  = 8'h7C;
    localparam logic [7:0] ESC_CHAR = 8'h7D;
    localparam logic [7:0] ESC_XOR  = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        CH_MARK,
        CH_ESC,
        CH_VAL,
        SOP_MARK,
        EOP_MARK,
        D_ESC,
        D_VAL
    } state_t;

    state_t                   state_q, state_d;
    logic                     out_valid_q, out_valid_d;
    logic [7:0]               out_data_q, out_data_d;
    logic                     last_ch_vld_q, last_ch_vld_d;
    logic [CHANNEL_WIDTH-1:0] last_ch_q, last_ch_d;

    logic [7:0] ch_byte;
    logic       ch_special;
    logic       data_special;
    logic       ch_new;
    logic       load;
    logic       pending;
    state_t     start_step;
    state_t     data_step;
    state_t     step;
    state_t     next_step;
    logic [7:0] step_byte;

    function automatic logic is_special(input logic [7:0] b);
        return (b >= SOP_CHAR) && (b <= ESC_CHAR);
    endfunction

    assign ch_byte      = 8'(bus.in_channel);
    assign ch_special   = is_special(ch_byte);
    assign data_special = is_special(bus.in_data);
    assign ch_new       = !last_ch_vld_q || (bus.in_channel != last_ch_q);
    assign load         = !out_valid_q || bus.out_ready;
    // Upstream holds in_valid for the whole beat, so it doubles as "byte pending".
    assign pending      = bus.in_valid;

    always_comb begin
        data_step  = data_special ? D_ESC : D_VAL;
        start_step = data_step;
        if (bus.in_startofpacket && ch_new) begin
            start_step = CH_MARK;
        end else if (bus.in_startofpacket) begin
            start_step = SOP_MARK;
        end else if (bus.in_endofpacket) begin
            start_step = EOP_MARK;
        end
        // IDLE resolves the first step combinationally so beats run back to back.
        step = (state_q == IDLE) ? start_step : state_q;
    end

    always_comb begin
        step_byte = 8'h00;
        next_step = IDLE;
        case (step)
            CH_MARK: begin
                step_byte = CH_CHAR;
                next_step = ch_special ? CH_ESC : CH_VAL;
            end
            CH_ESC: begin
                step_byte = ESC_CHAR;
                next_step = CH_VAL;
            end
            CH_VAL: begin
                step_byte = ch_special ? (ch_byte ^ ESC_XOR) : ch_byte;
                next_step = SOP_MARK;
            end
            SOP_MARK: begin
                step_byte = SOP_CHAR;
                next_step = bus.in_endofpacket ? EOP_MARK : data_step;
            end
            EOP_MARK: begin
                step_byte = EOP_CHAR;
                next_step = data_step;
            end
            D_ESC: begin
                step_byte = ESC_CHAR;
                next_step = D_VAL;
            end
            D_VAL: begin
                step_byte = data_special ? (bus.in_data ^ ESC_XOR) : bus.in_data;
                next_step = IDLE;
            end
            default: begin
                step_byte = 8'h00;
                next_step = IDLE;
            end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        last_ch_vld_d = last_ch_vld_q;
        last_ch_d     = last_ch_q;
        if (load) begin
            out_valid_d = pending;
            if (pending) begin
                out_data_d = step_byte;
                state_d    = next_step;
                if (step == CH_VAL) begin
                    last_ch_d     = bus.in_channel;
                    last_ch_vld_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'h00;
            last_ch_vld_q <= 1'b0;
            last_ch_q     <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            last_ch_vld_q <= last_ch_vld_d;
            last_ch_q     <= last_ch_d;
        end
    end

    assign bus.in_ready  = !reset && (step == D_VAL) && load && bus.in_valid;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_lcd_master_0_p2b_converter.sv
// Directed bench for the packets-to-bytes encoder: checks byte streams, timing,
// stalls and mid-sequence reset against hand-computed expected sequences.
module tb_lcd_master_0_p2b_converter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;
    int   pulses;
    int   ir_cyc;
    bit   rdy_mode;
    int   ph;
    logic [3:0] pat;
    bit   prev_stall;
    logic [7:0] prev_dat;

    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic [7:0] exp_q[$];

    lcd_master_0_p2b_converter_if #(.CHANNEL_WIDTH(8)) bus();

    lcd_master_0_p2b_converter #(.CHANNEL_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rdy_mode) begin
            bus.out_ready = pat[ph];
            ph = (ph + 1) % 4;
        end else begin
            bus.out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(bus.out_data);
                got_cyc.push_back(cyc);
            end
            if (bus.in_ready && bus.in_valid) begin
                pulses++;
                ir_cyc = cyc;
            end
            if (prev_stall) begin
                chk("stall_hold_dat", {24'h0, bus.out_data}, {24'h0, prev_dat});
                chk("stall_hold_vld", {31'h0, bus.out_valid}, 32'h1);
            end
            if (bus.out_valid && !bus.out_ready)
                chk("stall_no_in_ready", {31'h0, bus.in_ready}, 32'h0);
        end
        prev_stall = !reset && bus.out_valid && !bus.out_ready;
        prev_dat   = bus.out_data;
    end

    task automatic send_beat(input bit sop, input bit eop, input logic [7:0] ch,
                             input logic [7:0] dat);
        bit ok;
        ok = 1'b0;
        bus.in_startofpacket = sop;
        bus.in_endofpacket   = eop;
        bus.in_channel       = ch;
        bus.in_data          = dat;
        bus.in_valid         = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("beat_accept", {31'h0, ok}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", {31'h0, ok}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag, input bit consec);
        int n;
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
            if (consec)
                chk($sformatf("%s_cyc%0d", tag, i), got_cyc[i], got_cyc[0] + i);
        end
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        int drive_cyc;
        bit ok;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        pulses   = 0;
        ir_cyc   = 0;
        ph       = 0;
        pat      = 4'b1001;
        rdy_mode = 1'b0;
        prev_stall = 1'b0;
        prev_dat = 8'h00;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        // Plain data beat held during reset: in_ready must still stay low.
        bus.in_valid = 1'b1;
        bus.in_startofpacket = 1'b0;
        bus.in_endofpacket = 1'b0;
        bus.in_channel = 8'h00;
        bus.in_data = 8'h11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_out_data", {24'h0, bus.out_data}, 32'h0);
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        got_q.delete();
        got_cyc.delete();
        pulses = 0;

        // 1: single-beat packet, latency and in_ready timing
        drive_cyc = cyc;
        send_beat(1, 1, 8'h00, 8'h55);
        idle();
        chk("t1_pulses", pulses, 1);
        chk("t1_latency", got_cyc.size() > 0 ? got_cyc[0] : -1, drive_cyc + 1);
        chk("t1_ready_cyc", got_cyc.size() > 4 ? got_cyc[4] : -1, ir_cyc + 1);
        exp_q = '{8'h7C, 8'h00, 8'h7A, 8'h7B, 8'h55};
        check_stream("t1", 1);

        // 2: four-beat packet with escaped payload
        pulses = 0;
        send_beat(1, 0, 8'h03, 8'h11);
        send_beat(0, 0, 8'h03, 8'h7A);
        send_beat(0, 0, 8'h03, 8'h7D);
        send_beat(0, 1, 8'h03, 8'h22);
        idle();
        chk("t2_pulses", pulses, 4);
        exp_q = '{8'h7C, 8'h03, 8'h7A, 8'h11, 8'h7D, 8'h5A, 8'h7D, 8'h5D, 8'h7B, 8'h22};
        check_stream("t2", 1);

        // 3: special-valued channel gets escaped
        send_beat(1, 0, 8'h7B, 8'h00);
        idle();
        exp_q = '{8'h7C, 8'h7D, 8'h5B, 8'h7A, 8'h00};
        check_stream("t3", 1);

        // 4: repeated channel suppresses marker, new channel re-emits it
        send_beat(1, 1, 8'h05, 8'h10);
        send_beat(1, 1, 8'h05, 8'h20);
        idle();
        exp_q = '{8'h7C, 8'h05, 8'h7A, 8'h7B, 8'h10, 8'h7A, 8'h7B, 8'h20};
        check_stream("t4a", 1);
        send_beat(1, 1, 8'h06, 8'h30);
        idle();
        exp_q = '{8'h7C, 8'h06, 8'h7A, 8'h7B, 8'h30};
        check_stream("t4b", 1);

        // EOP with no SOP is encoded as-is
        send_beat(0, 1, 8'h06, 8'h41);
        idle();
        exp_q = '{8'h7B, 8'h41};
        check_stream("t4c", 1);

        // 5: scenario 2 under out_ready pattern 1,0,0,1
        rdy_mode = 1'b1;
        pulses = 0;
        send_beat(1, 0, 8'h03, 8'h11);
        send_beat(0, 0, 8'h03, 8'h7A);
        send_beat(0, 0, 8'h03, 8'h7D);
        send_beat(0, 1, 8'h03, 8'h22);
        idle();
        rdy_mode = 1'b0;
        chk("t5_pulses", pulses, 4);
        exp_q = '{8'h7C, 8'h03, 8'h7A, 8'h11, 8'h7D, 8'h5A, 8'h7D, 8'h5D, 8'h7B, 8'h22};
        check_stream("t5", 0);

        // 6: reset while 0x7D of an escape pair is on out_data
        @(posedge clk);
        #1;
        bus.in_startofpacket = 1'b1;
        bus.in_endofpacket   = 1'b1;
        bus.in_channel       = 8'h03;
        bus.in_data          = 8'h7D;
        bus.in_valid         = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_data == 8'h7D) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t6_reach_esc", {31'h0, ok}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("t6_rst_out_data", {24'h0, bus.out_data}, 32'h0);
        chk("t6_rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        got_q.delete();
        got_cyc.delete();
        @(posedge clk);
        #1;
        send_beat(1, 1, 8'h03, 8'h7D);
        idle();
        exp_q = '{8'h7C, 8'h03, 8'h7A, 8'h7B, 8'h7D, 8'h5D};
        check_stream("t6", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_master_0_p2b_converter.md
Name: lcd_master_0_p2b_converter

Overview:
- Packets-to-bytes encoder directly downstream of the channel adapter in the LCD master bridge return path.
- Accepts one Avalon-ST beat (data, channel, SOP, EOP) and serialises it into a flat byte stream for the host byte link.
- Framing uses in-band special characters: 0x7A SOP, 0x7B EOP, 0x7C channel marker, 0x7D escape.
- Registered output with full ready/valid backpressure.

Parameters:
- CHANNEL_WIDTH, 8, width of in_channel (1..8); zero-extended to 8 bits when emitted.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- in_ready  output  1  current input beat consumed this cycle
- in_valid  input  1  input beat valid
- in_data  input  8  payload byte
- in_channel  input  CHANNEL_WIDTH  channel of the beat; sampled only on SOP beats
- in_startofpacket  input  1  first beat of packet
- in_endofpacket  input  1  last beat of packet
- out_ready  input  1  downstream accepts byte
- out_valid  output  1  out_data valid
- out_data  output  8  encoded byte

Behaviour:
- Reset, asynchronous:
  - out_valid=0, out_data=0x00, sequencer returns to first step.
  - last_channel_valid=0, last_channel=0.
  - in_ready=0 while reset is asserted.
- Encoding per beat, emitted in this order:
  1. If SOP and (!last_channel_valid or channel != last_channel): 0x7C, then the channel byte. The channel byte is escaped if it lies in 0x7A..0x7D.
  2. If SOP: 0x7A.
  3. If EOP: 0x7B.
  4. Data byte: if in 0x7A..0x7D, emit 0x7D then data^0x20; otherwise emit data.
- Escape rule: an escaped byte is the pair 0x7D, (byte XOR 0x20).
- Sequencer states: IDLE, CH_MARK, CH_ESC, CH_VAL, SOP_MARK, EOP_MARK, D_ESC, D_VAL.
  - From IDLE, when in_valid is high, go to the first applicable step.
  - Each step advances only when the output register loads.
  - D_VAL, or D_ESC followed by D_VAL, is always the final step of a beat.
- Output register:
  - load = !out_valid || out_ready.
  - On load with a byte pending: out_data <= byte, out_valid <= 1.
  - On load with nothing pending: out_valid <= 0.
  - out_data is held stable while out_valid && !out_ready.
- in_ready = (state is final data step) && load && in_valid.
  - Combinational from out_ready.
  - Exactly one pulse per beat.
- Channel tracking: when the channel byte is loaded, last_channel <= in_channel and last_channel_valid <= 1.
- Latency: the first byte of a beat appears on out_valid the cycle after in_valid is first seen with load=1.
- Throughput: one unescaped non-SOP/non-EOP data beat per cycle under continuous out_ready; no bubble between beats.
- Input rule: per Avalon-ST, the upstream holds all in_* stable while in_valid && !in_ready. Behaviour is undefined if it does not; no checking is required.
- in_valid dropping between beats: the sequencer idles in IDLE and out_valid clears after the last byte drains.
- EOP without a prior SOP: encoded as-is; the block does no packet-integrity checking.
- Reset mid-sequence: the partial encoding is discarded. The next SOP re-emits the channel marker because last_channel_valid is cleared.

Test Plan:
1. After reset, beat {SOP=1, EOP=1, ch=0x00, data=0x55}, out_ready=1 -> out stream 7C 00 7A 7B 55 on five consecutive cycles; in_ready pulses once, on the cycle 0x55 loads.
2. Packet ch=0x03 with data 11, 7A, 7D, 22 (SOP on first beat, EOP on last) -> 7C 03 7A 11 7D 5A 7D 5D 7B 22.
3. SOP beat with ch=0x7B, data=0x00 -> 7C 7D 5B 7A 00; last_channel=0x7B.
4. Two back-to-back single-beat packets on ch=0x05 (data 0x10, then 0x20):
   - first -> 7C 05 7A 7B 10
   - second -> 7A 7B 20, with no channel marker
   - then a packet on ch=0x06 -> re-emits 7C 06.
5. Scenario 2 with out_ready toggling 1,0,0,1 repeating -> identical byte sequence; out_data stable on every stalled cycle; no duplicated or lost bytes; in_ready never high while a stall blocks the load.
6. Assert reset while 0x7D of an escape pair is on out_data -> out_valid=0 immediately; after release, replaying the SOP beat with the same channel -> stream starts 7C ch again.
